// File: rtl/set_assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
// set_assoc_cache_ctrl : N-way write-through, no-write-allocate data cache
// with true-LRU replacement and multi-beat SRAM line fill.      Rev 1.0
// ============================================================================
module set_assoc_cache_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int WA_W  = ADDR_W - 2;
    localparam int TAG_W = WA_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RESP  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WA_W-1:0]   req_wa_q, req_wa_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAY_W-1:0]  age_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_d [SETS][WAYS];
    logic [DATA_W-1:0] data_q [SETS][WAYS][WORDS];
    logic [TAG_W-1:0]  tag_q [SETS][WAYS];

    logic [TAG_W-1:0] a_tag, r_tag;
    logic [IDX_W-1:0] a_idx, r_idx;
    logic [OFF_W-1:0] a_off, r_off;
    logic             unused_byte_sel;

    assign a_tag = addr[ADDR_W-1 -: TAG_W];
    assign a_idx = addr[2+OFF_W +: IDX_W];
    assign a_off = addr[2 +: OFF_W];
    assign r_tag = req_wa_q[WA_W-1 -: TAG_W];
    assign r_idx = req_wa_q[OFF_W +: IDX_W];
    assign r_off = req_wa_q[OFF_W-1:0];
    assign unused_byte_sel = ^addr[1:0];

    logic             hit;
    logic [WAY_W-1:0] hit_way, victim;

    // Victim: lowest-index invalid way wins, otherwise the oldest way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (age_q[a_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[a_idx][w]) victim = WAY_W'(w);
    end

    logic              flush_all, touch_en, fill_done, data_we, tag_we;
    logic [IDX_W-1:0]  touch_set, data_set;
    logic [WAY_W-1:0]  touch_way, data_way;
    logic [OFF_W-1:0]  data_word;
    logic [DATA_W-1:0] data_wdata;

    always_comb begin
        state_d     = state_q;
        req_wa_d    = req_wa_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        beat_d      = beat_q;
        ready       = 1'b0;
        rdata       = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        flush_all   = 1'b0;
        touch_en    = 1'b0;
        fill_done   = 1'b0;
        touch_set   = a_idx;
        touch_way   = hit_way;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        data_set    = a_idx;
        data_way    = hit_way;
        data_word   = a_off;
        data_wdata  = wdata;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    flush_all = 1'b1;
                end else if (wr_en) begin
                    data_we     = hit;
                    touch_en    = hit;
                    req_wa_d    = addr[ADDR_W-1:2];
                    req_wdata_d = wdata;
                    state_d     = S_WRITE;
                end else if (rd_en) begin
                    if (hit) begin
                        ready    = 1'b1;
                        rdata    = data_q[a_idx][hit_way][a_off];
                        touch_en = 1'b1;
                    end else begin
                        req_wa_d = addr[ADDR_W-1:2];
                        victim_d = victim;
                        beat_d   = '0;
                        state_d  = S_FILL;
                    end
                end
            end
            S_FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {r_tag, r_idx, beat_q, 2'b00};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    data_set   = r_idx;
                    data_way   = victim_q;
                    data_word  = beat_q;
                    data_wdata = mem_rdata;
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        tag_we    = 1'b1;
                        touch_en  = 1'b1;
                        fill_done = 1'b1;
                        touch_set = r_idx;
                        touch_way = victim_q;
                        beat_d    = '0;
                        state_d   = S_RESP;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end
            end
            S_RESP: begin
                ready   = 1'b1;
                rdata   = data_q[r_idx][victim_q][r_off];
                state_d = S_IDLE;
            end
            S_WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = {req_wa_q, 2'b00};
                mem_wdata = req_wdata_q;
                if (mem_ready) begin
                    ready   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are held quiet for the whole reset cycle.
        if (!rst) begin
            ready     = 1'b0;
            rdata     = '0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Touch: every way younger than the touched one ages by one.
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        if (flush_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
                for (int w = 0; w < WAYS; w++) age_d[s][w] = WAY_W'(w);
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++)
                if (age_q[touch_set][w] < age_q[touch_set][touch_way])
                    age_d[touch_set][w] = age_q[touch_set][w] + WAY_W'(1);
            age_d[touch_set][touch_way] = '0;
            if (fill_done) valid_d[touch_set][touch_way] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_wa_q    <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            beat_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q     <= state_d;
            req_wa_q    <= req_wa_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            beat_q      <= beat_d;
            valid_q     <= valid_d;
            age_q       <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && data_we) data_q[data_set][data_way][data_word] <= data_wdata;
        if (rst && tag_we)  tag_q[data_set][data_way] <= r_tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache_ctrl.sv
`default_nettype none
// Bench: a 2-way/64-set/2-word and a 4-way/16-set/4-word cache checked
// cycle by cycle against a timestamp-LRU transaction model and sparse SRAM.
module tb_set_assoc_cache_ctrl;
    localparam int AW = 19;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] addr      [2];
    logic          rd_en     [2];
    logic          wr_en     [2];
    logic [DW-1:0] wdata     [2];
    logic          flush     [2];
    logic [DW-1:0] rdata     [2];
    logic          ready     [2];
    logic [AW-1:0] mem_addr  [2];
    logic          mem_rd    [2];
    logic          mem_wr    [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          mem_ready [2];

    logic          exp_chk       [2];
    logic          exp_ready     [2];
    logic [DW-1:0] exp_rdata     [2];
    logic          exp_mem_rd    [2];
    logic          exp_mem_wr    [2];
    logic [AW-1:0] exp_mem_addr  [2];
    logic [DW-1:0] exp_mem_wdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        set_assoc_cache_ctrl #(
            .ADDR_W(AW), .DATA_W(DW),
            .WAYS(g == 0 ? 2 : 4), .SETS(g == 0 ? 64 : 16), .WORDS(g == 0 ? 2 : 4)
        ) u_dut (
            .clk(clk), .rst(rst), .addr(addr[g]), .rd_en(rd_en[g]), .wr_en(wr_en[g]),
            .wdata(wdata[g]), .flush(flush[g]), .rdata(rdata[g]), .ready(ready[g]),
            .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    bit            m_valid [2][64][4];
    int            m_tag   [2][64][4];
    longint        m_stamp [2][64][4];
    logic [DW-1:0] m_data  [2][64][4][4];
    longint        stamp_ctr = 1;
    logic [DW-1:0] sram [int];

    function automatic int ways(input int k);  return (k == 0) ? 2 : 4;  endfunction
    function automatic int sets(input int k);  return (k == 0) ? 64 : 16; endfunction
    function automatic int words(input int k); return (k == 0) ? 2 : 4;  endfunction
    function automatic int offw(input int k);  return (k == 0) ? 1 : 2;  endfunction
    function automatic int idxw(input int k);  return (k == 0) ? 6 : 4;  endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic int key(input int k, input logic [AW-1:0] a);
        return (k << 20) | (int'(a) >> 2);
    endfunction

    function automatic logic [DW-1:0] sram_rd(input int k, input logic [AW-1:0] a);
        if (sram.exists(key(k, a))) return sram[key(k, a)];
        return 32'(key(k, a) + 1) * 32'h9E37_79B1;
    endfunction

    // Recency by timestamp; initial stamps make way WAYS-1 the oldest.
    function automatic void model_reset(input int k);
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[k][s][w] = 1'b0;
                m_stamp[k][s][w] = -longint'(w);
            end
    endfunction

    function automatic int lookup(input int k, input int s, input int t);
        for (int w = 0; w < ways(k); w++)
            if (m_valid[k][s][w] && m_tag[k][s][w] == t) return w;
        return -1;
    endfunction

    function automatic int pick_victim(input int k, input int s);
        int v = 0;
        for (int w = 0; w < ways(k); w++) if (!m_valid[k][s][w]) return w;
        for (int w = 1; w < ways(k); w++) if (m_stamp[k][s][w] < m_stamp[k][s][v]) v = w;
        return v;
    endfunction

    function automatic void touch(input int k, input int s, input int w);
        m_stamp[k][s][w] = stamp_ctr;
        stamp_ctr++;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (exp_chk[k]) begin
                chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(exp_ready[k]));
                chk($sformatf("rdata[%0d]", k), rdata[k], exp_rdata[k]);
                chk($sformatf("mem_rd[%0d]", k), 32'(mem_rd[k]), 32'(exp_mem_rd[k]));
                chk($sformatf("mem_wr[%0d]", k), 32'(mem_wr[k]), 32'(exp_mem_wr[k]));
                chk($sformatf("mem_addr[%0d]", k), 32'(mem_addr[k]), 32'(exp_mem_addr[k]));
                chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k], exp_mem_wdata[k]);
            end
        end
    end

    task automatic set_idle(input int k);
        rd_en[k] = 1'b0; wr_en[k] = 1'b0; flush[k] = 1'b0;
        addr[k] = '0; wdata[k] = '0; mem_ready[k] = 1'b0; mem_rdata[k] = '0;
        exp_chk[k] = 1'b1; exp_ready[k] = 1'b0; exp_rdata[k] = '0;
        exp_mem_rd[k] = 1'b0; exp_mem_wr[k] = 1'b0; exp_mem_addr[k] = '0; exp_mem_wdata[k] = '0;
    endtask

    task automatic tick(input int k, output logic [DW-1:0] got);
        @(negedge clk);
        got = rdata[k];
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int k, input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] got);
        int s, t, o, w, v, nw;
        logic [AW-1:0] base, ba;
        logic [DW-1:0] bv, dummy;
        s = (int'(a) >> (2 + offw(k))) & (sets(k) - 1);
        t = int'(a) >> (2 + offw(k) + idxw(k));
        o = (int'(a) >> 2) & (words(k) - 1);
        base = a & ~AW'(words(k) * 4 - 1);
        w = lookup(k, s, t);
        hit = (w >= 0);
        set_idle(k); rd_en[k] = 1'b1; addr[k] = a;
        if (hit) begin
            exp_ready[k] = 1'b1;
            exp_rdata[k] = m_data[k][s][w][o];
            touch(k, s, w);
            tick(k, got);
        end else begin
            v = pick_victim(k, s);
            tick(k, dummy);
            for (int b = 0; b < words(k); b++) begin
                nw = $urandom_range(0, 3);
                ba = base | AW'(b * 4);
                for (int c = 0; c <= nw; c++) begin
                    set_idle(k);
                    rd_en[k] = 1'b1;
                    addr[k]  = AW'($urandom);
                    flush[k] = 1'($urandom_range(0, 1));
                    exp_mem_rd[k] = 1'b1;
                    exp_mem_addr[k] = ba;
                    if (c == nw) begin
                        bv = sram_rd(k, ba);
                        mem_ready[k] = 1'b1;
                        mem_rdata[k] = bv;
                        m_data[k][s][v][b] = bv;
                    end
                    tick(k, dummy);
                end
            end
            m_valid[k][s][v] = 1'b1;
            m_tag[k][s][v] = t;
            touch(k, s, v);
            set_idle(k); rd_en[k] = 1'b1; addr[k] = a;
            exp_ready[k] = 1'b1;
            exp_rdata[k] = m_data[k][s][v][o];
            tick(k, got);
        end
    endtask

    task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int s, t, o, w, nw;
        logic [DW-1:0] dummy;
        s = (int'(a) >> (2 + offw(k))) & (sets(k) - 1);
        t = int'(a) >> (2 + offw(k) + idxw(k));
        o = (int'(a) >> 2) & (words(k) - 1);
        w = lookup(k, s, t);
        set_idle(k); wr_en[k] = 1'b1; addr[k] = a; wdata[k] = d;
        rd_en[k] = 1'($urandom_range(0, 1));
        if (w >= 0) begin
            m_data[k][s][w][o] = d;
            touch(k, s, w);
        end
        tick(k, dummy);
        nw = $urandom_range(0, 3);
        for (int c = 0; c <= nw; c++) begin
            set_idle(k);
            wr_en[k] = 1'b1; addr[k] = AW'($urandom); wdata[k] = $urandom;
            exp_mem_wr[k] = 1'b1;
            exp_mem_addr[k] = a & ~AW'(3);
            exp_mem_wdata[k] = d;
            if (c == nw) begin
                mem_ready[k] = 1'b1;
                exp_ready[k] = 1'b1;
            end
            tick(k, dummy);
        end
        sram[key(k, a)] = d;
    endtask

    task automatic do_flush(input int k, input logic [AW-1:0] a);
        logic [DW-1:0] dummy;
        set_idle(k); flush[k] = 1'b1; rd_en[k] = 1'b1; addr[k] = a;
        model_reset(k);
        tick(k, dummy);
    endtask

    task automatic rand_phase(input int k, input int n);
        int tg, ix, wd, sel;
        logic [AW-1:0] a;
        bit h;
        logic [DW-1:0] g;
        for (int i = 0; i < n; i++) begin
            tg = $urandom_range(0, 5);
            ix = $urandom_range(0, 1);
            wd = $urandom_range(0, words(k) - 1);
            a = AW'((tg << (2 + offw(k) + idxw(k))) | (ix << (2 + offw(k))) | (wd << 2));
            sel = $urandom_range(0, 9);
            if (sel < 6)      do_read(k, a, h, g);
            else if (sel < 9) do_write(k, a, $urandom);
            else              do_flush(k, a);
            if ($urandom_range(0, 3) == 0) begin
                set_idle(k);
                tick(k, g);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        logic [DW-1:0] g;
        for (int k = 0; k < 2; k++) begin
            set_idle(k);
            exp_chk[k] = 1'b0;
            model_reset(k);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        set_idle(0); set_idle(1);
        tick(0, g);

        // 2-way directed sequence
        sram[key(0, 19'h00008)] = 32'h1111_1111;
        sram[key(0, 19'h0000C)] = 32'h2222_2222;
        do_read(0, 19'h00008, h, g);
        chk("cold_rd8_hit", 32'(h), 32'd0);
        chk("cold_rd8_data", g, 32'h1111_1111);
        do_read(0, 19'h0000C, h, g);
        chk("rdC_hit", 32'(h), 32'd1);
        chk("rdC_data", g, 32'h2222_2222);
        do_read(0, 19'h00208, h, g);
        chk("rd208_hit", 32'(h), 32'd0);
        do_read(0, 19'h00008, h, g);
        chk("rd8_rehit", 32'(h), 32'd1);
        do_read(0, 19'h00408, h, g);
        chk("rd408_hit", 32'(h), 32'd0);
        chk("rd408_way", 32'(lookup(0, 1, 2)), 32'd1);
        do_read(0, 19'h00008, h, g);
        chk("rd8_after_evict", 32'(h), 32'd1);
        do_read(0, 19'h00208, h, g);
        chk("rd208_evicted", 32'(h), 32'd0);
        do_write(0, 19'h0000C, 32'hDEAD_BEEF);
        do_read(0, 19'h0000C, h, g);
        chk("wr_hit_rd_hit", 32'(h), 32'd1);
        chk("wr_hit_rd_data", g, 32'hDEAD_BEEF);
        do_write(0, 19'h00608, 32'h1234_5678);
        do_read(0, 19'h00608, h, g);
        chk("wr_miss_no_alloc", 32'(h), 32'd0);
        chk("wr_miss_rd_data", g, 32'h1234_5678);
        do_flush(0, 19'h0000C);
        do_read(0, 19'h0000C, h, g);
        chk("flush_miss", 32'(h), 32'd0);

        // Reset while the second fill beat is outstanding
        do_flush(0, 19'h00008);
        set_idle(0); rd_en[0] = 1'b1; addr[0] = 19'h00008;
        tick(0, g);
        set_idle(0); rd_en[0] = 1'b1; addr[0] = 19'h00008;
        exp_mem_rd[0] = 1'b1; exp_mem_addr[0] = 19'h00008;
        mem_ready[0] = 1'b1; mem_rdata[0] = 32'hAAAA_0000;
        tick(0, g);
        set_idle(0); rd_en[0] = 1'b1; addr[0] = 19'h00008;
        mem_ready[0] = 1'b1; mem_rdata[0] = 32'hAAAA_0004;
        exp_chk[0] = 1'b0; exp_chk[1] = 1'b0;
        rst = 1'b0;
        tick(0, g);
        rst = 1'b1;
        set_idle(0); set_idle(1);
        model_reset(0); model_reset(1);
        tick(0, g);
        do_read(0, 19'h00008, h, g);
        chk("post_reset_miss", 32'(h), 32'd0);
        chk("post_reset_data", g, 32'h1111_1111);

        rand_phase(0, 150);
        set_idle(0);

        // 4-way LRU: tags 0..3 fill set 0, re-touch tag 0, tag 4 evicts tag 1
        for (int t = 0; t < 4; t++) begin
            do_read(1, AW'(t << 8), h, g);
            chk($sformatf("w4_cold_t%0d", t), 32'(h), 32'd0);
        end
        do_read(1, 19'h00000, h, g);
        chk("w4_retouch_t0", 32'(h), 32'd1);
        do_read(1, 19'h00400, h, g);
        chk("w4_t4_miss", 32'(h), 32'd0);
        chk("w4_t1_evicted", 32'(lookup(1, 0, 1)), 32'hFFFF_FFFF);
        do_read(1, 19'h00100, h, g);
        chk("w4_t1_refill", 32'(h), 32'd0);
        do_read(1, 19'h0000C, h, g);
        chk("w4_t0_kept", 32'(h), 32'd1);

        rand_phase(1, 150);
        set_idle(1);
        tick(1, g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
